// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin, packet-granular arbiter feeding one UART transmit handshake.
// Define UART_ARB_ID_HDR_EN to prefix every packet with a header byte 8'hA0 | grant_id.
module uart_tx_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int MAX_PKT_LEN = 64,
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int CW = $clog2(MAX_PKT_LEN + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [8*NUM_REQ-1:0] req_tdata,
  input  logic [NUM_REQ-1:0]   req_tlast,
  output logic                 tx_valid,
  input  logic                 tx_ready,
  output logic [7:0]           tx_tdata,
  output logic [IW-1:0]        grant_id,
  output logic                 busy
);
`ifdef UART_ARB_ID_HDR_EN
  typedef enum logic [1:0] {IDLE, HDR, DATA} state_t;
`else
  typedef enum logic [1:0] {IDLE, DATA} state_t;
`endif
  state_t state, state_nxt;
  logic [IW-1:0] rr_ptr, winner;
  logic [CW-1:0] cnt;
  logic found, xfer, pkt_end;
  function automatic logic [IW-1:0] wrap(input logic [IW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    return IW'((s >= NUM_REQ) ? s - NUM_REQ : s);
  endfunction
  // Scan downward so the lowest offset from rr_ptr is the last (winning) assignment.
  always_comb begin
    found = 1'b0;
    winner = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--)
      if (req_valid[wrap(rr_ptr, i)]) begin
        found = 1'b1;
        winner = wrap(rr_ptr, i);
      end
  end
  assign xfer = (state == DATA) && req_valid[grant_id] && tx_ready;
  assign pkt_end = xfer && (req_tlast[grant_id] || cnt == CW'(MAX_PKT_LEN - 1));
  assign busy = (state != IDLE);
  always_comb begin
    state_nxt = state;
    tx_valid = 1'b0;
    tx_tdata = 8'h00;
    req_ready = '0;
    case (state)
      IDLE: if (found) begin
`ifdef UART_ARB_ID_HDR_EN
        state_nxt = HDR;
`else
        state_nxt = DATA;
`endif
      end
`ifdef UART_ARB_ID_HDR_EN
      HDR: begin
        tx_valid = 1'b1;
        tx_tdata = 8'hA0 | 8'(grant_id);
        state_nxt = tx_ready ? DATA : HDR;
      end
`endif
      DATA: begin
        tx_valid = req_valid[grant_id];
        tx_tdata = req_tdata[8*grant_id +: 8];
        req_ready[grant_id] = tx_ready;
        state_nxt = pkt_end ? IDLE : DATA;
      end
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      grant_id <= '0;
      rr_ptr <= '0;
      cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && found) begin
        grant_id <= winner;
        cnt <= '0;
      end
      if (xfer) cnt <= cnt + 1'b1;
      if (pkt_end) rr_ptr <= (grant_id == IW'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: source queues drive the requesters; expected bytes sit in a scoreboard queue.
module tb_uart_tx_arbiter;
  logic clk = 1'b0, rst_n = 1'b0, tx_ready = 1'b1;
  logic [3:0] req_valid = '0, req_ready, req_tlast = '0;
  logic [31:0] req_tdata = '0;
  logic tx_valid, busy;
  logic [7:0] tx_tdata;
  logic [1:0] grant_id;
  typedef struct packed {logic [7:0] d; logic l;} beat_t;
  typedef struct packed {logic [1:0] id; logic [7:0] d;} exp_t;
  typedef struct {int id; int len; logic [7:0] base; int cyc; int bsy;} vec_t;
  beat_t srcq[4][$];
  exp_t sb[$];
  logic rdy_q[$];
  vec_t vt[6];
  int tests = 0, fails = 0, busy_cnt = 0;

  uart_tx_arbiter #(.NUM_REQ(4), .MAX_PKT_LEN(4)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_tdata(req_tdata), .req_tlast(req_tlast), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .tx_tdata(tx_tdata), .grant_id(grant_id), .busy(busy));

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask

  task automatic load(input int id, input int n, input logic [7:0] base);
    beat_t b;
    for (int k = 0; k < n; k++) begin
      b.d = base + 8'(k);
      b.l = (k == n - 1);
      srcq[id].push_back(b);
    end
  endtask

  task automatic expect_b(input int id, input int k0, input int n, input logic [7:0] base);
    exp_t e;
    for (int k = k0; k < k0 + n; k++) begin
      e.id = 2'(id);
      e.d = base + 8'(k);
      sb.push_back(e);
    end
  endtask

  task automatic step();
    @(negedge clk);
    tx_ready = (rdy_q.size() != 0) ? rdy_q.pop_front() : 1'b1;
    for (int i = 0; i < 4; i++) begin
      req_valid[i] = (srcq[i].size() != 0);
      req_tdata[8*i +: 8] = req_valid[i] ? srcq[i][0].d : 8'h00;
      req_tlast[i] = req_valid[i] && srcq[i][0].l;
    end
    #1;
    busy_cnt += int'(busy);
    if (tx_valid) begin
      if (sb.size() == 0) chk("unexpected_tx", {24'h0, tx_tdata}, 32'hFFFF_FFFF);
      else begin
        chk("tx_tdata", {24'h0, tx_tdata}, {24'h0, sb[0].d});
        chk("grant_id", {30'h0, grant_id}, {30'h0, sb[0].id});
        chk("req_ready", {28'h0, req_ready}, tx_ready ? (32'h1 << sb[0].id) : 32'h0);
        if (tx_ready) void'(sb.pop_front());
      end
    end
    for (int i = 0; i < 4; i++)
      if (req_valid[i] && req_ready[i]) void'(srcq[i].pop_front());
  endtask

  task automatic run(input string nm, input int exp_cyc, input int exp_busy);
    int n;
    n = 0;
    busy_cnt = 0;
    while (sb.size() != 0 && n < 200) begin
      step();
      n++;
    end
    chk({nm, "_drain"}, sb.size(), 0);
    chk({nm, "_cycles"}, n, exp_cyc);
    chk({nm, "_busy"}, busy_cnt, exp_busy);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_tx_valid", {31'h0, tx_valid}, 0);
    chk("rst_tx_tdata", {24'h0, tx_tdata}, 0);
    chk("rst_req_ready", {28'h0, req_ready}, 0);
    chk("rst_grant_id", {30'h0, grant_id}, 0);
    chk("rst_busy", {31'h0, busy}, 0);
    for (int i = 0; i < 4; i++) srcq[i].delete();
    sb.delete();
    rdy_q.delete();
    req_valid = '0;
    req_tlast = '0;
    req_tdata = '0;
    tx_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    vt[0] = '{3, 1, 8'h40, 2, 1};
    vt[1] = '{0, 4, 8'h50, 5, 4};
    vt[2] = '{2, 2, 8'h60, 3, 2};
    vt[3] = '{1, 3, 8'hF0, 4, 3};
    vt[4] = '{1, 5, 8'h70, 7, 5};
    vt[5] = '{0, 1, 8'h00, 2, 1};
    do_reset();
    for (int v = 0; v < 6; v++) begin
      load(vt[v].id, vt[v].len, vt[v].base);
      expect_b(vt[v].id, 0, vt[v].len, vt[v].base);
      run("table", vt[v].cyc, vt[v].bsy);
    end
    // single requester 1: 11,22,33
    do_reset();
    srcq[1].push_back('{8'h11, 1'b0});
    srcq[1].push_back('{8'h22, 1'b0});
    srcq[1].push_back('{8'h33, 1'b1});
    sb.push_back('{2'd1, 8'h11});
    sb.push_back('{2'd1, 8'h22});
    sb.push_back('{2'd1, 8'h33});
    run("single", 4, 3);
    // rr_ptr is now 2, so req 2 beats req 1; reset lands after its second byte
    load(1, 1, 8'h90);
    load(2, 5, 8'hB0);
    expect_b(2, 0, 5, 8'hB0);
    repeat (3) step();
    chk("rr_after_single", sb.size(), 3);
    do_reset();
    load(0, 2, 8'hA1);
    load(2, 5, 8'hB0);
    expect_b(0, 0, 2, 8'hA1);
    expect_b(2, 0, 4, 8'hB0);
    expect_b(2, 4, 1, 8'hB0);
    run("after_reset", 10, 7);
    // contention from reset
    do_reset();
    for (int r = 0; r < 4; r++) load(r, 2, 8'(8'h10 * (r + 1)));
    for (int r = 0; r < 4; r++) expect_b(r, 0, 2, 8'(8'h10 * (r + 1)));
    run("contention", 12, 8);
    // backpressure
    load(2, 3, 8'hC1);
    expect_b(2, 0, 3, 8'hC1);
    rdy_q = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    run("backpressure", 6, 5);
    // length limit with req 2 waiting
    do_reset();
    load(0, 6, 8'hD1);
    load(2, 2, 8'hE1);
    expect_b(0, 0, 4, 8'hD1);
    expect_b(2, 0, 2, 8'hE1);
    expect_b(0, 4, 2, 8'hD1);
    run("length_limit", 11, 8);
    step();
    chk("final_idle", {31'h0, busy}, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
